// File: rtl/exec_datapath_pkg.sv
// ============================================================================
// Module      : exec_datapath_pkg
// Description : Shared constants for the execution datapath. This package
//               defines the expanded 6-bit opcodes, the PSR bit indices and
//               the register ids. It also provides the ALU result struct and
//               a byte-merge helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package exec_datapath_pkg;

  // Expanded opcodes
  localparam logic [5:0] OP_LD_B   = 6'h00;
  localparam logic [5:0] OP_LD_H   = 6'h02;
  localparam logic [5:0] OP_LD_W   = 6'h04;
  localparam logic [5:0] OP_STO_B  = 6'h08;
  localparam logic [5:0] OP_STO_H  = 6'h0A;
  localparam logic [5:0] OP_STO_W  = 6'h0C;
  localparam logic [5:0] OP_JRCC   = 6'h10;
  localparam logic [5:0] OP_JRSRCC = 6'h12;
  localparam logic [5:0] OP_JMP    = 6'h14;
  localparam logic [5:0] OP_JSR    = 6'h16;
  localparam logic [5:0] OP_LMOVT  = 6'h18;
  localparam logic [5:0] OP_LMOV   = 6'h1C;
  localparam logic [5:0] OP_MOV    = 6'h20;
  localparam logic [5:0] OP_AND    = 6'h22;
  localparam logic [5:0] OP_OR     = 6'h24;
  localparam logic [5:0] OP_XOR    = 6'h26;
  localparam logic [5:0] OP_ADD    = 6'h28;
  localparam logic [5:0] OP_ADC    = 6'h2A;
  localparam logic [5:0] OP_SUB    = 6'h2C;
  localparam logic [5:0] OP_SBC    = 6'h2E;
  localparam logic [5:0] OP_ASR    = 6'h30;
  localparam logic [5:0] OP_LSR    = 6'h32;
  localparam logic [5:0] OP_ASL    = 6'h34;
  localparam logic [5:0] OP_ROR    = 6'h36;
  localparam logic [5:0] OP_MUL    = 6'h38;
  localparam logic [5:0] OP_NOT    = 6'h3A;
  localparam logic [5:0] OP_RSV0   = 6'h3C;
  localparam logic [5:0] OP_RSV1   = 6'h3E;

  // PSR bit indices
  localparam int PSR_C = 0;
  localparam int PSR_V = 1;
  localparam int PSR_S = 2;
  localparam int PSR_Z = 3;

  // Register ids
  localparam logic [3:0] RPC = 4'd15;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [DATA_W-1:0] dout;
    logic              cout;
    logic              vout;
  } alu_res_t;

  // Replace the bytes of old_val whose enable bit is set with bytes of new_val
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [3:0]        be
  );
    logic [DATA_W-1:0] res;
    res = old_val;
    for (int n = 0; n < 4; n++) begin
      if (be[n]) res[8*n +: 8] = new_val[8*n +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exec_datapath_grf1w2r.sv
// ============================================================================
// Module      : exec_datapath_grf1w2r
// Description : General register file with 16 x 32-bit registers. It has one
//               byte-enabled synchronous write port and two asynchronous read
//               ports. An asynchronous active-low reset clears it.
//               Option macro: GRF_BYPASS_EN forwards the byte-merged write
//               data to a read of the register being written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_datapath_grf1w2r
  import exec_datapath_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstb,
  input  logic              i_clk_en,
  input  logic              i_cs_b,
  input  logic [3:0]        i_waddr,
  input  logic [3:0]        i_wen,
  input  logic [DATA_W-1:0] i_din,
  input  logic [3:0]        i_raddr_0,
  input  logic [3:0]        i_raddr_1,
  output logic [DATA_W-1:0] o_dout_0,
  output logic [DATA_W-1:0] o_dout_1
);

  logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] mem_d;
  logic                            we;

  // A write needs both the global clock enable and the active-low chip select
  assign we = i_clk_en & ~i_cs_b;

  // Next-state: byte-merge the write data into the addressed register only
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[i_waddr] = byte_merge(mem_q[i_waddr], i_din, i_wen);
    end
  end

  // Register array state, cleared asynchronously
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef GRF_BYPASS_EN
  // mem_d already holds the merged value of a register written this cycle
  assign o_dout_0 = mem_d[i_raddr_0];
  assign o_dout_1 = mem_d[i_raddr_1];
`else
  // Reads return stored contents; the pipeline resolves RAW hazards by stalling
  assign o_dout_0 = mem_q[i_raddr_0];
  assign o_dout_1 = mem_q[i_raddr_1];
`endif

endmodule

`default_nettype wire

// File: rtl/exec_datapath.sv
// ============================================================================
// Module      : exec_datapath
// Description : Execution datapath. This is the register file plus the
//               combinational ALU, barrel shifter and 32x32 multiplier.
//               o_mcp flags the 2-cycle multiply path.
//               Option macro: GRF_BYPASS_EN (register-file write bypass).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_datapath
  import exec_datapath_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstb,
  input  logic              i_clk_en,
  input  logic              i_cs_b,
  input  logic [3:0]        i_waddr,
  input  logic [3:0]        i_wen,
  input  logic [DATA_W-1:0] i_din,
  input  logic [3:0]        i_raddr_0,
  input  logic [3:0]        i_raddr_1,
  output logic [DATA_W-1:0] o_dout_0,
  output logic [DATA_W-1:0] o_dout_1,
  input  logic [DATA_W-1:0] i_din_a,
  input  logic [DATA_W-1:0] i_din_b,
  input  logic              i_cin,
  input  logic              i_vin,
  input  logic [5:0]        i_opcode,
  output logic [DATA_W-1:0] o_alu_dout,
  output logic              o_cout,
  output logic              o_vout,
  output logic              o_mcp
);

  exec_datapath_grf1w2r u_grf1w2r (
    .i_clk     (i_clk),
    .i_rstb    (i_rstb),
    .i_clk_en  (i_clk_en),
    .i_cs_b    (i_cs_b),
    .i_waddr   (i_waddr),
    .i_wen     (i_wen),
    .i_din     (i_din),
    .i_raddr_0 (i_raddr_0),
    .i_raddr_1 (i_raddr_1),
    .o_dout_0  (o_dout_0),
    .o_dout_1  (o_dout_1)
  );

  // --------------------------------------------------------------------------
  // Adder/subtractor: subtraction is a + ~b + carry_in, with ARM carry semantics
  // --------------------------------------------------------------------------
  logic              add_sub;
  logic              add_cin;
  logic [DATA_W-1:0] add_b;
  logic [DATA_W:0]   add_sum;
  logic              add_ovf;

  assign add_sub = (i_opcode == OP_SUB) || (i_opcode == OP_SBC);
  assign add_b   = add_sub ? ~i_din_b : i_din_b;

  // Carry into the adder: 0 for ADD, 1 for SUB, PSR carry for ADC/SBC
  always_comb begin
    add_cin = 1'b0;
    case (i_opcode)
      OP_ADC:  add_cin = i_cin;
      OP_SUB:  add_cin = 1'b1;
      OP_SBC:  add_cin = i_cin;
      default: add_cin = 1'b0;
    endcase
  end

  assign add_sum = {1'b0, i_din_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
  // Signed overflow: both operands share a sign that the result does not
  assign add_ovf = (i_din_a[DATA_W-1] == add_b[DATA_W-1]) &&
                   (add_sum[DATA_W-1] != i_din_a[DATA_W-1]);

  // --------------------------------------------------------------------------
  // Barrel shifter: each form keeps one extra bit that catches the last bit out
  // --------------------------------------------------------------------------
  logic [4:0]          sh_amt;
  logic [DATA_W:0]     lsr_ext;
  logic [DATA_W:0]     asr_ext;
  logic [DATA_W:0]     asl_ext;
  logic [2*DATA_W-1:0] ror_ext;

  assign sh_amt  = i_din_b[4:0];
  assign lsr_ext = {i_din_a, 1'b0} >> sh_amt;
  assign asr_ext = $signed({i_din_a, 1'b0}) >>> sh_amt;
  assign asl_ext = {1'b0, i_din_a} << sh_amt;
  assign ror_ext = {i_din_a, i_din_a} >> sh_amt;

  // 32x32 multiply keeps the low word only; it is timed as a 2-cycle path
  logic [DATA_W-1:0] mul_lo;
  assign mul_lo = i_din_a * i_din_b;

  // --------------------------------------------------------------------------
  // Result and flag select. Flags pass through unless the op defines them.
  // --------------------------------------------------------------------------
  alu_res_t res;

  // Select the result of the presented opcode
  always_comb begin
    res = '{dout: i_din_b, cout: i_cin, vout: i_vin};
    case (i_opcode)
      OP_LD_B, OP_LD_H, OP_LD_W, OP_STO_B, OP_STO_H, OP_STO_W,
      OP_JRCC, OP_JRSRCC, OP_JMP, OP_JSR, OP_MOV,
      OP_RSV0, OP_RSV1: res.dout = i_din_b;
      OP_LMOVT:         res.dout = {i_din_b[15:0], 16'h0000};
      OP_LMOV:          res.dout = {16'h0000, i_din_b[15:0]};
      OP_AND:           res.dout = i_din_a & i_din_b;
      OP_OR:            res.dout = i_din_a | i_din_b;
      OP_XOR:           res.dout = i_din_a ^ i_din_b;
      OP_NOT:           res.dout = ~i_din_b;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
        res.dout = add_sum[DATA_W-1:0];
        res.cout = add_sum[DATA_W];
        res.vout = add_ovf;
      end
      OP_ASR: begin
        res.dout = asr_ext[DATA_W:1];
        if (sh_amt != 5'd0) res.cout = asr_ext[0];
      end
      OP_LSR: begin
        res.dout = lsr_ext[DATA_W:1];
        if (sh_amt != 5'd0) res.cout = lsr_ext[0];
      end
      OP_ASL: begin
        res.dout = asl_ext[DATA_W-1:0];
        if (sh_amt != 5'd0) res.cout = asl_ext[DATA_W];
      end
      OP_ROR: begin
        res.dout = ror_ext[DATA_W-1:0];
        // The last bit rotated out lands in the result MSB
        if (sh_amt != 5'd0) res.cout = ror_ext[DATA_W-1];
      end
      OP_MUL:           res.dout = mul_lo;
      default:          res.dout = i_din_b;
    endcase
  end

  assign o_alu_dout = res.dout;
  assign o_cout     = res.cout;
  assign o_vout     = res.vout;
  assign o_mcp      = (i_opcode == OP_MUL);

endmodule

`default_nettype wire

// File: tb/tb_exec_datapath.sv
// ============================================================================
// Module      : tb_exec_datapath
// Description : Directed self-checking bench for exec_datapath. It covers
//               register-file writes and reads, plus ALU results and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_datapath;

  logic        i_clk;
  logic        i_rstb;
  logic        i_clk_en;
  logic        i_cs_b;
  logic [3:0]  i_waddr;
  logic [3:0]  i_wen;
  logic [31:0] i_din;
  logic [3:0]  i_raddr_0;
  logic [3:0]  i_raddr_1;
  logic [31:0] o_dout_0;
  logic [31:0] o_dout_1;
  logic [31:0] i_din_a;
  logic [31:0] i_din_b;
  logic        i_cin;
  logic        i_vin;
  logic [5:0]  i_opcode;
  logic [31:0] o_alu_dout;
  logic        o_cout;
  logic        o_vout;
  logic        o_mcp;

  int checks;
  int errors;

  exec_datapath dut (
    .i_clk      (i_clk),
    .i_rstb     (i_rstb),
    .i_clk_en   (i_clk_en),
    .i_cs_b     (i_cs_b),
    .i_waddr    (i_waddr),
    .i_wen      (i_wen),
    .i_din      (i_din),
    .i_raddr_0  (i_raddr_0),
    .i_raddr_1  (i_raddr_1),
    .o_dout_0   (o_dout_0),
    .o_dout_1   (o_dout_1),
    .i_din_a    (i_din_a),
    .i_din_b    (i_din_b),
    .i_cin      (i_cin),
    .i_vin      (i_vin),
    .i_opcode   (i_opcode),
    .o_alu_dout (o_alu_dout),
    .o_cout     (o_cout),
    .o_vout     (o_vout),
    .o_mcp      (o_mcp)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One register-file write cycle, driven on the falling edge
  task automatic grf_write(input logic [3:0] addr, input logic [3:0] be, input logic [31:0] data,
                           input logic cs_b, input logic clk_en);
    @(negedge i_clk);
    i_waddr  = addr;
    i_wen    = be;
    i_din    = data;
    i_cs_b   = cs_b;
    i_clk_en = clk_en;
    @(posedge i_clk);
    #1;
    i_cs_b   = 1'b1;
    i_clk_en = 1'b1;
    i_wen    = 4'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    i_raddr_0 = addr;
    i_raddr_1 = addr;
    #1;
    check_eq({tag, "_p0"}, o_dout_0, exp);
    check_eq({tag, "_p1"}, o_dout_1, exp);
  endtask

  task automatic alu_chk(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cin, input logic vin,
                         input logic [31:0] exp_d, input logic exp_c, input logic exp_v);
    i_opcode = op;
    i_din_a  = a;
    i_din_b  = b;
    i_cin    = cin;
    i_vin    = vin;
    #1;
    check_eq({tag, "_dout"}, o_alu_dout, exp_d);
    check_eq({tag, "_c"}, {31'b0, o_cout}, {31'b0, exp_c});
    check_eq({tag, "_v"}, {31'b0, o_vout}, {31'b0, exp_v});
    check_eq({tag, "_mcp"}, {31'b0, o_mcp}, {31'b0, (op == 6'h38)});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    i_rstb    = 1'b0;
    i_clk_en  = 1'b1;
    i_cs_b    = 1'b1;
    i_waddr   = 4'h0;
    i_wen     = 4'h0;
    i_din     = 32'h0;
    i_raddr_0 = 4'h0;
    i_raddr_1 = 4'h0;
    i_din_a   = 32'h0;
    i_din_b   = 32'h0;
    i_cin     = 1'b0;
    i_vin     = 1'b0;
    i_opcode  = 6'h00;

    // Reset: all registers read back zero on both ports
    repeat (2) @(posedge i_clk);
    for (int i = 0; i < 16; i++) begin
      i_raddr_0 = 4'(i);
      i_raddr_1 = 4'(15 - i);
      #1;
      check_eq($sformatf("rst_r%0d_p0", i), o_dout_0, 32'h0);
      check_eq($sformatf("rst_r%0d_p1", i), o_dout_1, 32'h0);
    end
    @(negedge i_clk);
    i_rstb = 1'b1;

    // Full-word write; same-cycle read sees old value unless bypass is built in
    @(negedge i_clk);
    i_waddr   = 4'd3;
    i_wen     = 4'hF;
    i_din     = 32'hDEADBEEF;
    i_cs_b    = 1'b0;
    i_raddr_0 = 4'd3;
    #1;
`ifdef GRF_BYPASS_EN
    check_eq("same_cycle_read", o_dout_0, 32'hDEADBEEF);
`else
    check_eq("same_cycle_read", o_dout_0, 32'h0);
`endif
    @(posedge i_clk);
    #1;
    i_cs_b = 1'b1;
    i_wen  = 4'h0;
    rd_chk("wr_full", 4'd3, 32'hDEADBEEF);

    // Partial byte writes
    grf_write(4'd3, 4'b0011, 32'h12345678, 1'b0, 1'b1);
    rd_chk("wr_low_half", 4'd3, 32'hDEAD5678);
    grf_write(4'd3, 4'b0100, 32'h00AA0000, 1'b0, 1'b1);
    rd_chk("wr_byte2", 4'd3, 32'hDEAA5678);

    // Writes that must be ignored
    grf_write(4'd3, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b1);
    rd_chk("wr_csb_hi", 4'd3, 32'hDEAA5678);
    grf_write(4'd3, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0);
    rd_chk("wr_clken_lo", 4'd3, 32'hDEAA5678);
    grf_write(4'd3, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b1);
    rd_chk("wr_wen_zero", 4'd3, 32'hDEAA5678);

    // Address decode: r0 and r15 are ordinary and independent
    grf_write(4'd15, 4'hF, 32'hCAFE0015, 1'b0, 1'b1);
    grf_write(4'd0,  4'hF, 32'h0BAD0000, 1'b0, 1'b1);
    i_raddr_0 = 4'd15;
    i_raddr_1 = 4'd0;
    #1;
    check_eq("r15_p0", o_dout_0, 32'hCAFE0015);
    check_eq("r0_p1", o_dout_1, 32'h0BAD0000);
    rd_chk("r3_kept", 4'd3, 32'hDEAA5678);
    rd_chk("r4_zero", 4'd4, 32'h0);

    // ALU vectors
    alu_chk("add_ovf",   6'h28, 32'h7FFFFFFF, 32'h1, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1);
    alu_chk("add_carry", 6'h28, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0);
    alu_chk("adc",       6'h2A, 32'h1,        32'h1, 1'b1, 1'b0, 32'h3,        1'b0, 1'b0);
    alu_chk("sub_pos",   6'h2C, 32'h5,        32'h3, 1'b0, 1'b1, 32'h2,        1'b1, 1'b0);
    alu_chk("sub_neg",   6'h2C, 32'h3,        32'h5, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
    alu_chk("sub_ovf",   6'h2C, 32'h80000000, 32'h1, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    alu_chk("sbc",       6'h2E, 32'h5,        32'h3, 1'b0, 1'b0, 32'h1,        1'b1, 1'b0);
    alu_chk("asr",       6'h30, 32'h80000000, 32'h4, 1'b1, 1'b1, 32'hF8000000, 1'b0, 1'b1);
    alu_chk("lsr",       6'h32, 32'h3,        32'h1, 1'b0, 1'b0, 32'h1,        1'b1, 1'b0);
    alu_chk("asl",       6'h34, 32'h80000001, 32'h1, 1'b0, 1'b0, 32'h2,        1'b1, 1'b0);
    alu_chk("ror",       6'h36, 32'h1,        32'h1, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0);
    alu_chk("lsr0_c1",   6'h32, 32'h12,       32'h20, 1'b1, 1'b0, 32'h12,       1'b1, 1'b0);
    alu_chk("asl0_c0",   6'h34, 32'h80000000, 32'h0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1);
    alu_chk("mul",       6'h38, 32'h00010000, 32'h00010001, 1'b1, 1'b0, 32'h00010000, 1'b1, 1'b0);
    alu_chk("lmovt",     6'h18, 32'h0, 32'hFFFFABCD, 1'b0, 1'b0, 32'hABCD0000, 1'b0, 1'b0);
    alu_chk("lmov",      6'h1C, 32'h0, 32'hFFFFABCD, 1'b1, 1'b1, 32'h0000ABCD, 1'b1, 1'b1);
    alu_chk("and",       6'h22, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'hF000F000, 1'b0, 1'b0);
    alu_chk("or",        6'h24, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'hFFF0FFF0, 1'b0, 1'b0);
    alu_chk("xor",       6'h26, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0, 32'h0FF00FF0, 1'b0, 1'b0);
    alu_chk("not",       6'h3A, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b0, 32'h00FF00FF, 1'b1, 1'b0);
    alu_chk("mov",       6'h20, 32'h11111111, 32'h22222222, 1'b0, 1'b1, 32'h22222222, 1'b0, 1'b1);
    alu_chk("ld_w",      6'h04, 32'h11111111, 32'h33333333, 1'b1, 1'b0, 32'h33333333, 1'b1, 1'b0);
    alu_chk("rsv",       6'h3C, 32'h11111111, 32'h44444444, 1'b0, 1'b0, 32'h44444444, 1'b0, 1'b0);

    // Asynchronous reset clears registers without a clock edge
    @(negedge i_clk);
    #2;
    i_rstb = 1'b0;
    #1;
    rd_chk("async_rst_r3", 4'd3, 32'h0);
    rd_chk("async_rst_r15", 4'd15, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
